mul_csa_iter: RTL

Iterative carry-save multiplier for the rv32v multiply lane. It retires BITS_PER_CYCLE multiplier bits per cycle into a redundant sum/carry accumulator built from chained 3:2 compressor rows. One carry-propagate add and sign fix-up then produce the result. It supports all four RV multiply modes behind a valid/ready handshake, and trades latency for area against a full array multiplier.

---
 rtl/mul_pkg.sv | 29 ++
 rtl/mul_csa_iter_if.sv | 31 +++
 rtl/mul_csa_stage.sv | 38 +++
 rtl/mul_csa_iter.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared types for the iterative carry-save multiplier.
//   mul_mode_t  : RV multiply flavour (low half, or high half with a given signedness)
//   mul_state_t : control FSM states
//   a_is_signed / b_is_signed : which operands are treated as two's complement
package mul_pkg;

  typedef enum logic [1:0] {
    MUL    = 2'b00,  // low half, signedness irrelevant
    MULH   = 2'b01,  // high half, signed x signed
    MULHSU = 2'b10,  // high half, signed x unsigned
    MULHU  = 2'b11   // high half, unsigned x unsigned
  } mul_mode_t;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    ADD,
    DONE
  } mul_state_t;

  function automatic logic a_is_signed(mul_mode_t m);
    return (m == MULH) || (m == MULHSU);
  endfunction

  function automatic logic b_is_signed(mul_mode_t m);
    return (m == MULH);
  endfunction

endpackage

// File: rtl/mul_csa_iter_if.sv
// Handshake bundle of the iterative multiplier.
//   master : producer/consumer side (drives operands, flush, out_ready)
//   slave  : multiplier side (drives in_ready, out_valid, result)
// Signals: in_valid/in_ready, mode, a, b (request); flush (abort);
//          out_valid/out_ready, result (response).
interface mul_csa_iter_if #(
  parameter int BIT_WIDTH = 32
);
  import mul_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  mul_mode_t            mode;
  logic [BIT_WIDTH-1:0] a;
  logic [BIT_WIDTH-1:0] b;
  logic                 flush;
  logic                 out_valid;
  logic                 out_ready;
  logic [BIT_WIDTH-1:0] result;

  modport master (
    output in_valid, mode, a, b, flush, out_ready,
    input  in_ready, out_valid, result
  );

  modport slave (
    input  in_valid, mode, a, b, flush, out_ready,
    output in_ready, out_valid, result
  );

endinterface

// File: rtl/mul_csa_stage.sv
// Combinational carry-save compression stage.
// Folds K partial products into a redundant sum/carry pair with K chained
// 3:2 compressor rows; each row's carry vector is shifted left by one and
// truncated to WIDTH, so sum_o + carry_o == sum_i + carry_i + sum(pp_i)
// modulo 2^WIDTH.
//   sum_i, carry_i : incoming redundant accumulator
//   pp_i           : K partial products
//   sum_o, carry_o : compressed accumulator
module mul_csa_stage #(
  parameter int WIDTH = 64,
  parameter int K     = 2
) (
  input  logic [WIDTH-1:0]        sum_i,
  input  logic [WIDTH-1:0]        carry_i,
  input  logic [K-1:0][WIDTH-1:0] pp_i,
  output logic [WIDTH-1:0]        sum_o,
  output logic [WIDTH-1:0]        carry_o
);

  always_comb begin
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] c;
    logic [WIDTH-1:0] maj;
    // NOTE: blocking assignments here model the row-to-row ripple; each row
    // must see the previous row's result within the same evaluation.
    s   = sum_i;
    c   = carry_i;
    maj = '0;
    for (int j = 0; j < K; j++) begin
      maj = (s & c) | (s & pp_i[j]) | (c & pp_i[j]);
      s   = s ^ c ^ pp_i[j];
      c   = maj << 1;
    end
    sum_o   = s;
    carry_o = c;
  end

endmodule

// File: rtl/mul_csa_iter.sv
// Iterative carry-save multiplier for the RV multiply lane.
// Operands are latched as unsigned magnitudes plus a result sign; each BUSY
// cycle retires BITS_PER_CYCLE multiplier bits into a redundant sum/carry
// accumulator, then a single carry-propagate add and conditional negation
// produce the 2*BIT_WIDTH product, of which one half is returned.
//   CLK   : clock, rising edge
//   nRST  : asynchronous active-low reset
//   bus   : request (in_valid/in_ready, mode, a, b), flush,
//           response (out_valid/out_ready, result)
module mul_csa_iter
  import mul_pkg::*;
#(
  parameter int BIT_WIDTH      = 32,
  parameter int BITS_PER_CYCLE = 2
) (
  input logic          CLK,
  input logic          nRST,
  mul_csa_iter_if.slave bus
);

  localparam int PW    = 2 * BIT_WIDTH;
  localparam int K     = BITS_PER_CYCLE;
  localparam int N     = BIT_WIDTH / K;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam int IDX_W = $clog2(BIT_WIDTH);

  mul_state_t           state_q, state_d;
  mul_mode_t            mode_q, mode_d;
  logic [BIT_WIDTH-1:0] a_mag_q, a_mag_d;
  logic [BIT_WIDTH-1:0] b_mag_q, b_mag_d;
  logic                 neg_q, neg_d;
  logic [PW-1:0]        sum_q, sum_d;
  logic [PW-1:0]        carry_q, carry_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BIT_WIDTH-1:0] result_q, result_d;

  logic [K-1:0][PW-1:0] pp;
  logic [PW-1:0]        stage_sum;
  logic [PW-1:0]        stage_carry;
  logic [PW-1:0]        prod_mag;
  logic [PW-1:0]        prod;

  // Partial products for multiplier bits cnt*K .. cnt*K+K-1.
  always_comb begin
    logic [IDX_W-1:0] base;
    logic [IDX_W-1:0] idx;
    base = IDX_W'(cnt_q) * IDX_W'(K);
    idx  = base;
    pp   = '0;
    for (int j = 0; j < K; j++) begin
      idx   = base + IDX_W'(j);
      pp[j] = b_mag_q[idx] ? (PW'(a_mag_q) << idx) : '0;
    end
  end

  mul_csa_stage #(
    .WIDTH (PW),
    .K     (K)
  ) u_stage (
    .sum_i   (sum_q),
    .carry_i (carry_q),
    .pp_i    (pp),
    .sum_o   (stage_sum),
    .carry_o (stage_carry)
  );

  // Magnitude product is below 2^PW, so the negation cannot overflow.
  assign prod_mag = sum_q + carry_q;
  assign prod     = neg_q ? (~prod_mag + PW'(1)) : prod_mag;

  always_comb begin
    // NOTE: every next-state signal gets its hold value first so no path
    // through the case below can leave it unassigned and infer a latch.
    state_d  = state_q;
    mode_d   = mode_q;
    a_mag_d  = a_mag_q;
    b_mag_d  = b_mag_q;
    neg_d    = neg_q;
    sum_d    = sum_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    result_d = result_q;

    if (bus.flush && (state_q != IDLE)) begin
      // Abort wins over everything, including a pending out_ready.
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          // A flush in IDLE blocks acceptance for that cycle.
          if (bus.in_valid && !bus.flush) begin
            a_mag_d = (a_is_signed(bus.mode) && bus.a[BIT_WIDTH-1]) ? -bus.a : bus.a;
            b_mag_d = (b_is_signed(bus.mode) && bus.b[BIT_WIDTH-1]) ? -bus.b : bus.b;
            neg_d   = (a_is_signed(bus.mode) && bus.a[BIT_WIDTH-1]) ^
                      (b_is_signed(bus.mode) && bus.b[BIT_WIDTH-1]);
            mode_d  = bus.mode;
            sum_d   = '0;
            carry_d = '0;
            cnt_d   = '0;
            state_d = BUSY;
          end
        end
        BUSY: begin
          sum_d   = stage_sum;
          carry_d = stage_carry;
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(N - 1)) begin
            state_d = ADD;
          end
        end
        ADD: begin
          result_d = (mode_q == MUL) ? prod[BIT_WIDTH-1:0] : prod[PW-1:BIT_WIDTH];
          state_d  = DONE;
        end
        DONE: begin
          if (bus.out_ready) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= IDLE;
      mode_q   <= MUL;
      a_mag_q  <= '0;
      b_mag_q  <= '0;
      neg_q    <= 1'b0;
      sum_q    <= '0;
      carry_q  <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values and the
      // update order inside this block does not matter.
      state_q  <= state_d;
      mode_q   <= mode_d;
      a_mag_q  <= a_mag_d;
      b_mag_q  <= b_mag_d;
      neg_q    <= neg_d;
      sum_q    <= sum_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  // Outputs decode registered state only; no path from in_valid or out_ready.
  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.result    = result_q;

endmodule
